// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared operation codes and FSM state encoding for alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] COP_CLR   = 4'b0000;
  localparam logic [3:0] COP_ADD   = 4'b0001;
  localparam logic [3:0] COP_SUB   = 4'b0010;
  localparam logic [3:0] COP_PASSB = 4'b0011;
  localparam logic [3:0] COP_CMPEQ = 4'b0100;
  localparam logic [3:0] COP_MUL   = 4'b0101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    HOLD     = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Purpose  : Operand/result valid-ready bus between read stage, alu_seq and
//            writeback. master = producer/consumer side, slave = the ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cop;
  logic [WIDTH-1:0] reg_A;
  logic [WIDTH-1:0] reg_B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, cop, reg_A, reg_B, out_ready,
    input  in_ready, out_valid, result, ovf, err
  );

  modport slave (
    input  in_valid, cop, reg_A, reg_B, out_ready,
    output in_ready, out_valid, result, ovf, err
  );

endinterface
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_mul
// Purpose  : Iterative shift-add multiplier. start latches operands; one
//            partial product per cycle for WIDTH cycles. done pulses on the
//            last iteration with product carrying the final accumulator value.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               start,
  input  wire logic [WIDTH-1:0]   mcand_in,
  input  wire logic [WIDTH-1:0]   mplier_in,
  output logic                    done,
  output logic [2*WIDTH-1:0]      product
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_step;

  // Next-state for one shift-add iteration, or operand load on start.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, mcand_in};
      mplier_d = mplier_in;
      acc_d    = '0;
      cnt_d    = CNT_INIT;
    end else if (cnt_q != '0) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      done     = (cnt_q == CW'(1));
    end
    product = acc_step;
  end

  // Multiplier state registers; reset aborts any iteration in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked sequential ALU. Single-cycle ops (CLR/ADD/SUB/PASSB/
//            CMPEQ) with one registered stage; MUL via alu_seq_mul over WIDTH
//            cycles. Output is held stable while writeback stalls.
// Options  : define ALU_SEQ_SAT_EN to saturate ADD/SUB/MUL instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  alu_seq_if.slave  bus
);

  import alu_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic               in_ready;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH-1:0]   op_res;
  logic               op_ovf;
  logic               op_err;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_ovf;

  // HOLD can take a new op in the same cycle its result drains.
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .mcand_in  (bus.reg_A),
    .mplier_in (bus.reg_B),
    .done      (mul_done),
    .product   (mul_product)
  );

  // Single-cycle datapath and multiplier result shaping.
  always_comb begin
    add_full = {1'b0, bus.reg_A} + {1'b0, bus.reg_B};
    sub_full = {1'b0, bus.reg_A} - {1'b0, bus.reg_B};
    op_res   = '0;
    op_ovf   = 1'b0;
    op_err   = 1'b0;
    case (bus.cop)
      COP_CLR:   op_res = '0;
      COP_ADD: begin
        op_res = add_full[WIDTH-1:0];
        op_ovf = add_full[WIDTH];
`ifdef ALU_SEQ_SAT_EN
        if (add_full[WIDTH]) op_res = '1;
`endif
      end
      COP_SUB: begin
        op_res = sub_full[WIDTH-1:0];
        op_ovf = sub_full[WIDTH];
`ifdef ALU_SEQ_SAT_EN
        if (sub_full[WIDTH]) op_res = '0;
`endif
      end
      COP_PASSB: op_res = bus.reg_B;
      COP_CMPEQ: op_res = {{(WIDTH-1){1'b0}}, (bus.reg_A == bus.reg_B)};
      COP_MUL:   op_res = '0;
      default:   op_err = 1'b1;
    endcase
    mul_ovf = |mul_product[2*WIDTH-1:WIDTH];
    mul_res = mul_product[WIDTH-1:0];
`ifdef ALU_SEQ_SAT_EN
    if (mul_ovf) mul_res = '1;
`endif
  end

  // Handshake FSM next-state: accept, multiply wait, and result hold.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (in_ready) begin
          if (bus.in_valid) begin
            if (bus.cop == COP_MUL) begin
              mul_start = 1'b1;
              state_d   = MUL_BUSY;
            end else begin
              state_d  = HOLD;
              result_d = op_res;
              ovf_d    = op_ovf;
              err_d    = op_err;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          state_d  = HOLD;
          result_d = mul_res;
          ovf_d    = mul_ovf;
          err_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq: directed corner cases, then
//            randomized ops with random writeback stalls against a
//            behavioural model and an in-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 16;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   cyc;
  bit   rand_rdy;
  logic [W+1:0] exp_q[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {err, ovf, result} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint unsigned la, lb, mask, r;
    logic o, e;
    la = a; lb = b; mask = (64'd1 << W) - 1;
    r = 0; o = 1'b0; e = 1'b0;
    case (c)
      4'd0: r = 0;
      4'd1: begin
        r = la + lb; o = (r > mask); r = r & mask;
`ifdef ALU_SEQ_SAT_EN
        if (o) r = mask;
`endif
      end
      4'd2: begin
        o = (la < lb); r = (la - lb) & mask;
`ifdef ALU_SEQ_SAT_EN
        if (o) r = 0;
`endif
      end
      4'd3: r = lb;
      4'd4: r = (la == lb) ? 1 : 0;
      4'd5: begin
        r = la * lb; o = (r > mask); r = r & mask;
`ifdef ALU_SEQ_SAT_EN
        if (o) r = mask;
`endif
      end
      default: e = 1'b1;
    endcase
    return {e, o, r[W-1:0]};
  endfunction

  // Output side: every transfer must match the oldest outstanding op.
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", {16'd0, bus.result}, {16'd0, e[W-1:0]});
        check("sb_ovf", {31'd0, bus.ovf}, {31'd0, e[W]});
        check("sb_err", {31'd0, bus.err}, {31'd0, e[W+1]});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    int w;
    got = 0;
    w = 0;
    bus.in_valid = 1'b1;
    bus.cop      = c;
    bus.reg_A    = a;
    bus.reg_B    = b;
    while (!got && w < 200) begin
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.in_ready) begin
        got = 1;
      end else begin
        @(posedge clk); #1;
        w++;
      end
    end
    if (!got) begin
      check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    end else begin
      exp_q.push_back(model(c, a, b));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.cop      = 4'($urandom);
    bus.reg_A    = W'($urandom);
    bus.reg_B    = W'($urandom);
  endtask

  task automatic check_now(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    logic [W+1:0] e;
    e = model(c, a, b);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_result"}, {16'd0, bus.result}, {16'd0, e[W-1:0]});
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, e[W]});
    check({tag, "_err"}, {31'd0, bus.err}, {31'd0, e[W+1]});
  endtask

  task automatic mul_latency(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    send(4'd5, a, b);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, W);
    check_now(tag, 4'd5, a, b);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] sa, sb;
    int t0;
    int k;
    n_vec = 0; n_err = 0; cyc = 0; rand_rdy = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.cop = '0; bus.reg_A = '0; bus.reg_B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Single-cycle ops: one-cycle latency and flag boundaries.
    send(4'd1, 16'hFFFF, 16'h0001); check_now("add_wrap", 4'd1, 16'hFFFF, 16'h0001);
    send(4'd1, 16'hFFFF, 16'hFFFF); check_now("add_max", 4'd1, 16'hFFFF, 16'hFFFF);
    send(4'd2, 16'h0003, 16'h0005); check_now("sub_borrow", 4'd2, 16'h0003, 16'h0005);
    send(4'd2, 16'h1234, 16'h1234); check_now("sub_equal", 4'd2, 16'h1234, 16'h1234);
    send(4'd2, 16'h0001, 16'h0002); check_now("sub_small", 4'd2, 16'h0001, 16'h0002);
    send(4'd4, 16'h1234, 16'h1234); check_now("cmpeq_eq", 4'd4, 16'h1234, 16'h1234);
    send(4'd4, 16'h1234, 16'h1235); check_now("cmpeq_ne", 4'd4, 16'h1234, 16'h1235);
    send(4'd3, 16'hAAAA, 16'h5A5A); check_now("passb", 4'd3, 16'hAAAA, 16'h5A5A);
    send(4'd10, 16'h1111, 16'h2222); check_now("illegal", 4'd10, 16'h1111, 16'h2222);
    send(4'd0, 16'hFFFF, 16'hFFFF); check_now("clr", 4'd0, 16'hFFFF, 16'hFFFF);

    // Multiply: fixed WIDTH-cycle latency regardless of operands.
    mul_latency("mul_ff_101", 16'h00FF, 16'h0101);
    mul_latency("mul_ovf", 16'h0100, 16'h0100);
    mul_latency("mul_zero", 16'hBEEF, 16'h0000);
    mul_latency("mul_max", 16'hFFFF, 16'hFFFF);

    // Writeback stall: output frozen and input blocked.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(4'd1, 16'h7000, 16'h9001);
    held = bus.result;
    check_now("stall_first", 4'd1, 16'h7000, 16'h9001);
    for (int i = 0; i < 5; i++) begin
      check("stall_result", {16'd0, bus.result}, {16'd0, held});
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sa = W'($urandom); sb = W'($urandom);
      t0 = cyc;
      send(4'd1, sa, sb);
      check("stream_cycles", cyc - t0, 1);
      check_now("stream", 4'd1, sa, sb);
    end

    // Reset in the middle of a multiply.
    send(4'd5, 16'h1234, 16'h5678);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_result", {16'd0, bus.result}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (20) begin
      check("midrst_no_out", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    send(4'd1, 16'd2, 16'd3); check_now("post_rst_add", 4'd1, 16'd2, 16'd3);

    // Randomized traffic with random writeback backpressure.
    rand_rdy = 1;
    repeat (300) begin
      logic [3:0] c;
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      send(c, pick(), pick());
    end
    rand_rdy = 0;
    bus.out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
